// File: rtl/fsm_pkg.sv
// Shared FSM and level definitions for the start/stop ramp controllers.
package fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_S100    = 3'd1,
    ST_S50     = 3'd2,
    ST_S30     = 3'd3,
    ST_STOPPED = 3'd4
  } state_t;

  // One-hot levels, bit order {100, 50, 30}
  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_30  = 3'b001;
  localparam logic [2:0] L_50  = 3'b010;
  localparam logic [2:0] L_100 = 3'b100;

  localparam int PCT_OFF = 0;
  localparam int PCT_30  = 30;
  localparam int PCT_50  = 50;
  localparam int PCT_100 = 100;

  // Multi-hot levels collapse to the highest set bit
  function automatic logic [2:0] resolve_lvl(input logic [2:0] lvl);
    if (lvl[2])      return L_100;
    else if (lvl[1]) return L_50;
    else if (lvl[0]) return L_30;
    else             return L_OFF;
  endfunction

  function automatic int lvl_pct(input logic [2:0] lvl);
    case (resolve_lvl(lvl))
      L_100:   return PCT_100;
      L_50:    return PCT_50;
      L_30:    return PCT_30;
      default: return PCT_OFF;
    endcase
  endfunction

  // Ramp entry state for a given (possibly multi-hot) level
  function automatic state_t lvl_to_state(input logic [2:0] lvl);
    case (resolve_lvl(lvl))
      L_100:   return ST_S100;
      L_50:    return ST_S50;
      L_30:    return ST_S30;
      default: return ST_STOPPED;
    endcase
  endfunction

endpackage

// File: rtl/pwm_nivel.sv
// PWM generator: drives one pin at the duty of a one-hot speed level.
// The period counter free-runs, so level changes take effect mid-period.
module pwm_nivel
  import fsm_pkg::*;
#(
  parameter int PWM_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lvl,
  output logic       pwm
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty;
  logic          pwm_q, pwm_d;

  // Duty and compare for the current count position
  always_comb begin
    duty  = CW'((PWM_PERIOD * lvl_pct(lvl)) / 100);
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    pwm_d = (cnt_q < duty);
  end

  // Period counter and registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/paro_rampa_parcial.sv
// Soft-stop controller: passes the start block's level through while idle,
// then on stop walks 100% -> 50% -> 30% -> off with a latched per-step dwell.
module paro_rampa_parcial
  import fsm_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DWELL_FAST = 1,
  parameter int DWELL_MID  = 2,
  parameter int DWELL_SLOW = 3,
  parameter int PWM_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop,
  input  logic       Rapido,
  input  logic       Lento,
  input  logic [2:0] lvl_in,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic       pwm,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [2:0]    lvl_q, lvl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0]    lvl_res;
  logic          tick;
  logic          step_end;

  assign lvl_res  = resolve_lvl(lvl_in);
  assign tick     = (presc_q == TICK_LAST);
  assign step_end = tick && (step_q == dwell_q - 8'd1);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      lvl_q   <= L_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, prescaler restart and dwell latching
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    step_d  = step_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = lvl_to_state(lvl_in);
          presc_d = '0;
          step_d  = '0;
          if (Lento)       dwell_d = 8'(DWELL_SLOW);
          else if (Rapido) dwell_d = 8'(DWELL_FAST);
          else             dwell_d = 8'(DWELL_MID);
        end
      end
      ST_S100, ST_S50, ST_S30: begin
        if (step_end) begin
          case (state_q)
            ST_S100: state_d = ST_S50;
            ST_S50:  state_d = ST_S30;
            default: state_d = ST_STOPPED;
          endcase
          presc_d = '0;
          step_d  = '0;
        end else if (tick) begin
          step_d = step_q + 8'd1;
        end
      end
      ST_STOPPED: begin
        if (!stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    lvl_d  = L_OFF;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE:    lvl_d = lvl_res;
      ST_S100:    begin lvl_d = L_100; busy_d = 1'b1; end
      ST_S50:     begin lvl_d = L_50;  busy_d = 1'b1; end
      ST_S30:     begin lvl_d = L_30;  busy_d = 1'b1; end
      ST_STOPPED: done_d = (state_q != ST_STOPPED);
      default:    lvl_d = L_OFF;
    endcase
  end

  pwm_nivel #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm (
    .clk  (clk),
    .reset(reset),
    .lvl  (lvl_q),
    .pwm  (pwm)
  );

  assign {out_100, out_50, out_30} = lvl_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_paro_rampa_parcial.sv
// Bench for the soft-stop controller: directed ramps plus random traffic,
// checked per cycle against a ramp-schedule reference model.
module tb_paro_rampa_parcial;

  localparam int TD = 4;
  localparam int DF = 1;
  localparam int DM = 2;
  localparam int DS = 3;
  localparam int PP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stop = 1'b0;
  logic       Rapido = 1'b0;
  logic       Lento = 1'b0;
  logic [2:0] lvl_in = 3'b000;
  logic       out_30, out_50, out_100, pwm, busy, done;

  always #5 clk = ~clk;

  paro_rampa_parcial #(
    .TICK_DIV  (TD),
    .DWELL_FAST(DF),
    .DWELL_MID (DM),
    .DWELL_SLOW(DS),
    .PWM_PERIOD(PP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .stop   (stop),
    .Rapido (Rapido),
    .Lento  (Lento),
    .lvl_in (lvl_in),
    .out_30 (out_30),
    .out_50 (out_50),
    .out_100(out_100),
    .pwm    (pwm),
    .busy   (busy),
    .done   (done)
  );

  typedef struct packed {
    logic [2:0] lvl;
    logic       busy;
    logic       done;
    logic       pwm;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  // Reference model: 0 idle, 1 ramping, 2 stopped; the ramp is a list of
  // percent levels, one entry per clock cycle still to be spent ramping.
  int mode = 0;
  int plan[$];
  int pcnt = 0;
  int prev_pct = 0;

  function automatic int resolve(input logic [2:0] l);
    if (l[2]) return 100;
    if (l[1]) return 50;
    if (l[0]) return 30;
    return 0;
  endfunction

  function automatic logic [2:0] pct2oh(input int p);
    case (p)
      100:     return 3'b100;
      50:      return 3'b010;
      30:      return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic ra,
                            input logic le, input logic [2:0] l);
    exp_t e;
    int   pct;
    int   d;
    int   start;
    int   ladder[3];
    ladder = '{100, 50, 30};
    e   = '0;
    pct = 0;
    if (r) begin
      mode     = 0;
      plan.delete();
      pcnt     = 0;
      prev_pct = 0;
    end else begin
      e.pwm = (pcnt < (PP * prev_pct) / 100);
      pcnt  = (pcnt + 1) % PP;
      if (mode == 0 && s) begin
        d     = le ? DS : (ra ? DF : DM);
        start = resolve(l);
        for (int i = 0; i < 3; i++)
          if (start != 0 && ladder[i] <= start)
            repeat (d * TD) plan.push_back(ladder[i]);
        mode = 1;
      end
      if (mode == 0) begin
        pct = resolve(l);
      end else if (mode == 1) begin
        if (plan.size() > 0) begin
          pct    = plan.pop_front();
          e.busy = 1'b1;
        end else begin
          mode   = 2;
          e.done = 1'b1;
        end
      end else begin
        if (!s) begin
          mode = 0;
          pct  = resolve(l);
        end
      end
      e.lvl    = pct2oh(pct);
      prev_pct = pct;
    end
    expq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic s, input logic ra,
                       input logic le, input logic [2:0] l);
    @(negedge clk);
    #1;
    reset  = r;
    stop   = s;
    Rapido = ra;
    Lento  = le;
    lvl_in = l;
    model_edge(r, s, ra, le, l);
  endtask

  // Monitor: one expected output vector per clock edge
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    cyc_n++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = '{lvl: {out_100, out_50, out_30}, busy: busy, done: done, pwm: pwm};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got lvl=%b busy=%b done=%b pwm=%b expected lvl=%b busy=%b done=%b pwm=%b",
                 cyc_n, a.lvl, a.busy, a.done, a.pwm, e.lvl, e.busy, e.done, e.pwm);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with level 100 present, then pass-through
    repeat (3) drive(1, 0, 0, 0, 3'b100);
    repeat (4) drive(0, 0, 0, 0, 3'b100);
    drive(0, 0, 0, 0, 3'b011);
    drive(0, 0, 0, 0, 3'b111);

    // Fast ramp from 100
    repeat (16) drive(0, 1, 1, 0, 3'b100);
    repeat (3)  drive(0, 0, 1, 0, 3'b100);

    // Slow ramp from 50, Lento beats Rapido; switch changes mid-ramp ignored
    drive(0, 1, 1, 1, 3'b010);
    repeat (10) drive(0, 1, 1, 0, 3'b010);
    repeat (18) drive(0, 1, 0, 0, 3'b111);
    repeat (3)  drive(0, 0, 0, 0, 3'b001);

    // Mid dwell, stop dropped after two cycles, inputs wiggle during ramp
    repeat (2) drive(0, 1, 0, 0, 3'b100);
    for (int i = 0; i < 26; i++)
      drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    repeat (3) drive(0, 0, 0, 0, 3'b010);

    // Reset in the middle of a ramp
    repeat (5) drive(0, 1, 1, 0, 3'b100);
    drive(1, 1, 1, 0, 3'b100);
    repeat (4) drive(0, 0, 0, 0, 3'b010);

    // PWM at 30 % and 100 %, then stop from level off
    repeat (25) drive(0, 0, 0, 0, 3'b001);
    repeat (15) drive(0, 0, 0, 0, 3'b100);
    repeat (3)  drive(0, 1, 0, 0, 3'b000);
    repeat (3)  drive(0, 0, 0, 0, 3'b000);

    // Random traffic with stop held in bursts and occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic s;
      s = (($urandom_range(0, 99) < 60) ? stop : ~stop);
      drive(1'($urandom_range(0, 299) == 0), s, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
